// File: rtl/ula_seq_ctrl.sv
// ---------------------------------------------------------------------------
// ula_seq_ctrl
//
// Sequencing controller for a chained ULA (ALU) datapath. The first operation
// of a chain takes its left operand from input A; every later operation takes
// the previous result held in `resultado`. Each accepted request spends
// exactly one cycle in EXEC. At the end of that cycle the ULA result is
// written back, or the controller parks in ERR if the ULA flagged an
// illegal operation.
//
// Ports
//   clk, rst_n         clock; asynchronous active-low reset
//   exec               request one operation (level, sampled on rising edge)
//   clear              abort / end the chain, back to first-operand mode
//   op_in[2:0]         operation code captured when a request is accepted
//   alu_result[W-1:0]  combinational ULA result for the operands in flight
//   alu_ovf, alu_err   ULA overflow and illegal-operation flags
//   sel_operando       operand mux select: 0 = input A, 1 = previous result
//   alu_op[2:0]        registered operation code driven to the ULA
//   resultado[W-1:0]   registered previous result
//   busy               high while an operation is in flight (EXEC)
//   done               one-cycle pulse after resultado was updated
//   err                high while in ERR
//   ovf_sticky         OR of alu_ovf over the write-backs of the chain
//   op_count[CNT_W-1:0] completed operations in the chain, saturating
//   dbg_state_o[1:0]   current FSM state, for observation only
//
// Handshake: `exec` is a level request with no queueing. It is accepted on a
// rising edge where the controller is EMPTY or READY and `clear` is low.
// `busy` is the not-ready indication: while it is high, and while in ERR,
// `exec` is ignored. `done` marks the write-back of an accepted request.
// ---------------------------------------------------------------------------
module ula_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             exec,
    input  logic             clear,
    input  logic [2:0]       op_in,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_ovf,
    input  logic             alu_err,
    output logic             sel_operando,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] resultado,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] op_count,
    output logic [1:0]       dbg_state_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_READY = 2'd1,
        ST_EXEC  = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic             sel_q, sel_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            sel_q   <= 1'b0;
            op_q    <= 3'd0;
            res_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            op_q    <= op_d;
            res_q   <= res_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        op_d    = op_q;
        res_d   = res_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        if (clear) begin
            // clear wins over exec and discards anything in flight; alu_op is
            // left as is because the ULA output is ignored outside EXEC.
            state_d = ST_EMPTY;
            sel_d   = 1'b0;
            res_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_EMPTY, ST_READY: begin
                    if (exec) begin
                        state_d = ST_EXEC;
                        op_d    = op_in;
                        // Chain continues from the held result only if one exists.
                        sel_d   = (state_q == ST_READY);
                    end
                end
                ST_EXEC: begin
                    if (alu_err) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_READY;
                        res_d   = alu_result;
                        done_d  = 1'b1;
                        ovf_d   = ovf_q | alu_ovf;
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_ERR: begin
                    state_d = ST_ERR;
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    assign sel_operando = sel_q;
    assign alu_op       = op_q;
    assign resultado    = res_q;
    assign busy         = (state_q == ST_EXEC);
    assign done         = done_q;
    assign err          = (state_q == ST_ERR);
    assign ovf_sticky   = ovf_q;
    assign op_count     = cnt_q;
    assign dbg_state_o  = state_q;

endmodule

// File: doc/ula_seq_ctrl.md
ULA_SEQ_CTRL -- requirements
Module: ula_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, data width of operands and results.
REQ-002 Parameter CNT_W, default 4, width of the chained-operation counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 exec  input  1  request one ULA operation, sampled on rising edge.
REQ-006 clear  input  1  abort or end the chain; return to first-operand mode.
REQ-007 op_in  input  3  operation code presented with exec.
REQ-008 alu_result  input  WIDTH  combinational ULA result for the operands in flight.
REQ-009 alu_ovf  input  1  ULA overflow/carry flag, valid with alu_result.
REQ-010 alu_err  input  1  ULA illegal-operation flag (e.g. divide by zero), valid with alu_result.
REQ-011 sel_operando  output  1  operand-mux select: 0 = input A, 1 = previous result.
REQ-012 alu_op  output  3  registered operation code driven to the ULA.
REQ-013 resultado  output  WIDTH  registered previous result; feeds the mux's previous-result input.
REQ-014 busy  output  1  high while an operation is in flight.
REQ-015 done  output  1  one-cycle pulse when resultado has been updated.
REQ-016 err  output  1  high while the controller is in the ERR state.
REQ-017 ovf_sticky  output  1  set by any overflowing write-back; cleared only by clear or reset.
REQ-018 op_count  output  CNT_W  number of completed operations in the current chain.

Function
REQ-019 FSM states: EMPTY (no previous result), READY (previous result held), EXEC (operation in flight), ERR (failed operation).
REQ-020 EMPTY or READY, exec=1, clear=0 -> EXEC; capture op_in into alu_op; sel_operando <= 0 from EMPTY, 1 from READY.
REQ-021 alu_op and sel_operando hold stable for the whole EXEC cycle.
REQ-022 EXEC is exactly one cycle; busy=1 only in EXEC.
REQ-023 EXEC, alu_err=0 -> resultado <= alu_result; done=1 for the next cycle; ovf_sticky |= alu_ovf; op_count increments; -> READY.
REQ-024 EXEC, alu_err=1 -> resultado, op_count and ovf_sticky unchanged; done stays 0; -> ERR.
REQ-025 Latency: exec sampled at edge N -> resultado updated and done=1 after edge N+1.
REQ-026 exec while in EXEC or ERR is ignored; requests are not queued.
REQ-027 exec asserted continuously from READY starts a new operation on the edge after done: one operation every 2 cycles.
REQ-028 op_count saturates at 2^CNT_W-1; further completions still update resultado and pulse done.
REQ-029 clear=1 in any state -> EMPTY; resultado <= 0, op_count <= 0, ovf_sticky <= 0, sel_operando <= 0, done <= 0.
REQ-030 clear has priority over exec when both are asserted on the same edge.
REQ-031 clear during EXEC aborts the operation; alu_result is discarded and done stays 0.
REQ-032 ERR is left only by clear or reset; err=1 exactly while in ERR.
REQ-033 WIDTH arithmetic is performed by the ULA; the controller only stores WIDTH bits, with no extension or truncation.

Reset
REQ-034 rst_n=0 immediately forces EMPTY and resultado=0, alu_op=0, sel_operando=0, busy=0, done=0, err=0, ovf_sticky=0, op_count=0.
REQ-035 Reset asserted during EXEC aborts the operation; no done pulse after release.
REQ-036 After rst_n deasserts, the first rising edge accepts exec normally.

Verification
REQ-037 Reset release, exec with op_in=3'b001 and alu_result=8'h12 -> sel_operando=0 during EXEC; then resultado=8'h12, done pulse, op_count=1, sel_operando=1 on the next exec.
REQ-038 Three chained execs with alu_result 8'h05, 8'h0A, 8'hFF (alu_ovf=1 on the 3rd) -> three done pulses 2 cycles apart, op_count=3, ovf_sticky=1, resultado=8'hFF.
REQ-039 READY with resultado=8'h0A, exec with alu_err=1 -> ERR, err=1, resultado stays 8'h0A, no done; exec ignored; clear -> EMPTY, resultado=0, err=0.
REQ-040 exec and clear on the same edge from READY -> EMPTY, no EXEC, busy never 1.
REQ-041 Seventeen completed operations with CNT_W=4 -> op_count holds 15; done still pulses 17 times.
REQ-042 rst_n pulled low mid-EXEC -> all outputs at reset values asynchronously; no done pulse after release.
